// File: rtl/mealy_seq_ctrl.sv
// mealy_seq_ctrl: streams a parallel pattern MSB-first into a Mealy machine
// after pulsing its reset, capturing the Mealy output into a result word and
// counting the captured 1s.
// Optional feature macro: MEALY_SEQ_STATE_CHK_EN adds a sticky state_err
// output that flags a Mealy state other than 0 when streaming begins.
module mealy_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] ones,
  output logic             fsm_rst_n,
  output logic             fsm_in,
  input  logic             fsm_out,
  input  logic [2:0]       fsm_state
`ifdef MEALY_SEQ_STATE_CHK_EN
  ,
  output logic             state_err
`endif
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] cnt;

`ifndef MEALY_SEQ_STATE_CHK_EN
  // Mealy state is only inspected by the optional check; fold it away here.
  logic unused_fsm_state;
  assign unused_fsm_state = ^fsm_state;
`endif

  // Sequencer FSM: all outputs are registered and updated in this one block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      ones      <= '0;
      fsm_in    <= 1'b0;
      fsm_rst_n <= 1'b0;
`ifdef MEALY_SEQ_STATE_CHK_EN
      state_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          fsm_rst_n <= 1'b1;
          fsm_in    <= 1'b0;
          busy      <= 1'b0;
          if (start) begin
            shreg     <= pattern;
            result    <= '0;
            ones      <= '0;
            cnt       <= '0;
            fsm_rst_n <= 1'b0;   // hold the Mealy in reset for the CLR cycle
            busy      <= 1'b1;
            state     <= CLR;
`ifdef MEALY_SEQ_STATE_CHK_EN
            state_err <= 1'b0;
`endif
          end
        end
        CLR: begin
          // Release the Mealy and present the MSB in the same edge.
          fsm_rst_n <= 1'b1;
          fsm_in    <= shreg[WIDTH-1];
          shreg     <= {shreg[WIDTH-2:0], 1'b0};
          state     <= RUN;
`ifdef MEALY_SEQ_STATE_CHK_EN
          if (fsm_state != 3'd0) begin
            state_err <= 1'b1;
          end
`endif
        end
        RUN: begin
          // fsm_out is combinational from the Mealy and the current fsm_in.
          result <= {result[WIDTH-2:0], fsm_out};
          ones   <= ones + CNT_W'(fsm_out);
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            fsm_in <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            fsm_in <= shreg[WIDTH-1];
            shreg  <= {shreg[WIDTH-2:0], 1'b0};
          end
        end
        DONE: begin
          // start is deliberately not looked at here.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
